// File: rtl/branch_commit_updater.sv
// branch_commit_updater: commit-side predictor update queue, committed RAS and mispredict redirect.
// Optional BCU_STATS_EN enables the committed-branch / mispredict counters.
`default_nettype none

module branch_commit_updater #(
  parameter int UPQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  cm_valid,
  input  logic [1:0]  cm_isbranch,
  input  logic [1:0]  cm_iscall,
  input  logic [1:0]  cm_isret,
  input  logic [1:0]  cm_taken,
  input  logic [1:0]  cm_pred_taken,
  input  logic [63:0] cm_pc,
  input  logic [63:0] cm_target,
  input  logic [63:0] cm_pred_target,
  output logic        cm_ready,
  output logic        wr_en,
  output logic [31:0] wr_PC,
  output logic [31:0] wr_target,
  output logic        wr_isret,
  output logic        wr_isjump,
  output logic        RAS_reset_en,
  output logic [63:0] RAS_reset_data,
  output logic        RAS_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  localparam int AW = $clog2(UPQ_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   q_pc  [UPQ_DEPTH];
  logic [31:0]   q_tgt [UPQ_DEPTH];
  logic          q_ret [UPQ_DEPTH];
  logic          q_jmp [UPQ_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [63:0]   ras;

  logic [31:0] pc0, pc1, tgt0, tgt1, pt0, pt1;
  logic        acc0, acc1, mis0, mis1, mis, empty, pop;
  logic [63:0] ras_a, ras_b, ras_before;
  logic [31:0] m_pc, m_tgt;
  logic        m_taken, m_isret, m_flush;

  // Ret pops before call pushes; pushed value is the return address word index.
  function automatic logic [63:0] ras_upd(input logic [63:0] r, input logic call,
                                          input logic ret, input logic [31:0] pc);
    logic [63:0] t;
    t = r;
    if (ret)  t = {16'b0, t[63:16]};
    if (call) t = {t[47:0], 16'((pc + 32'd8) >> 2)};
    return t;
  endfunction

  always_comb begin
    pc0  = cm_pc[31:0];          pc1  = cm_pc[63:32];
    tgt0 = cm_target[31:0];      tgt1 = cm_target[63:32];
    pt0  = cm_pred_target[31:0]; pt1  = cm_pred_target[63:32];

    acc0 = cm_valid[0] & cm_isbranch[0];
    mis0 = acc0 & ((cm_taken[0] != cm_pred_taken[0]) | (cm_taken[0] & (tgt0 != pt0)));
    // A slot0 mispredict squashes slot1 entirely.
    acc1 = cm_valid[1] & cm_isbranch[1] & ~mis0;
    mis1 = acc1 & ((cm_taken[1] != cm_pred_taken[1]) | (cm_taken[1] & (tgt1 != pt1)));
    mis  = mis0 | mis1;

    ras_a = acc0 ? ras_upd(ras, cm_iscall[0], cm_isret[0], pc0) : ras;
    ras_b = acc1 ? ras_upd(ras_a, cm_iscall[1], cm_isret[1], pc1) : ras_a;

    m_pc       = mis0 ? pc0 : pc1;
    m_tgt      = mis0 ? tgt0 : tgt1;
    m_taken    = mis0 ? cm_taken[0] : cm_taken[1];
    m_isret    = mis0 ? cm_isret[0] : cm_isret[1];
    ras_before = mis0 ? ras : ras_a;
    m_flush    = m_isret & (ras_before[15:0] == 16'h0);

    empty = (count == '0);
    pop   = ~empty;
  end

  assign cm_ready  = count <= CW'(UPQ_DEPTH - 2);
  assign wr_en     = ~empty;
  assign wr_PC     = empty ? 32'h0 : q_pc[rptr];
  assign wr_target = empty ? 32'h0 : q_tgt[rptr];
  assign wr_isret  = ~empty & q_ret[rptr];
  assign wr_isjump = ~empty & q_jmp[rptr];

  always_ff @(posedge clk) begin
    if (acc0) begin
      q_pc[wptr]  <= pc0;
      q_tgt[wptr] <= tgt0;
      q_ret[wptr] <= cm_isret[0];
      q_jmp[wptr] <= cm_taken[0];
    end
    if (acc1) begin
      q_pc[wptr + AW'(acc0)]  <= pc1;
      q_tgt[wptr + AW'(acc0)] <= tgt1;
      q_ret[wptr + AW'(acc0)] <= cm_isret[1];
      q_jmp[wptr + AW'(acc0)] <= cm_taken[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      ras            <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      RAS_reset_en   <= 1'b0;
      RAS_flush      <= 1'b0;
      RAS_reset_data <= '0;
    end else begin
      wptr           <= wptr + AW'(acc0) + AW'(acc1);
      rptr           <= rptr + AW'(pop);
      count          <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
      ras            <= ras_b;
      redirect_valid <= mis;
      RAS_reset_en   <= mis & ~m_flush;
      RAS_flush      <= mis & m_flush;
      if (mis) begin
        redirect_pc    <= m_taken ? m_tgt : m_pc + 32'd8;
        RAS_reset_data <= ras_b;
      end
    end
  end

`ifdef BCU_STATS_EN
  logic [31:0] br_cnt, mis_cnt;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      br_cnt  <= br_cnt + 32'(acc0) + 32'(acc1);
      mis_cnt <= mis_cnt + 32'(mis);
    end
  end
  assign stat_branches = br_cnt;
  assign stat_mispred  = mis_cnt;
`else
  assign stat_branches = 32'h0;
  assign stat_mispred  = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_commit_updater.sv
// Scoreboard bench for branch_commit_updater: predictor writes checked against a queue of expected entries.
`default_nettype none

module tb_branch_commit_updater;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  cm_valid = '0, cm_isbranch = '0, cm_iscall = '0, cm_isret = '0;
  logic [1:0]  cm_taken = '0, cm_pred_taken = '0;
  logic [63:0] cm_pc = '0, cm_target = '0, cm_pred_target = '0;
  logic        cm_ready, wr_en, wr_isret, wr_isjump, RAS_reset_en, RAS_flush, redirect_valid;
  logic [31:0] wr_PC, wr_target, redirect_pc, stat_branches, stat_mispred;
  logic [63:0] RAS_reset_data;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        isret;
    logic        isjump;
  } ent_t;

  ent_t sb[$];
  int   checks = 0, failures = 0;
  int   exp_br = 0, exp_mis = 0;

  branch_commit_updater #(.UPQ_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .cm_valid(cm_valid), .cm_isbranch(cm_isbranch), .cm_iscall(cm_iscall), .cm_isret(cm_isret),
    .cm_taken(cm_taken), .cm_pred_taken(cm_pred_taken),
    .cm_pc(cm_pc), .cm_target(cm_target), .cm_pred_target(cm_pred_target),
    .cm_ready(cm_ready), .wr_en(wr_en), .wr_PC(wr_PC), .wr_target(wr_target),
    .wr_isret(wr_isret), .wr_isjump(wr_isjump),
    .RAS_reset_en(RAS_reset_en), .RAS_reset_data(RAS_reset_data), .RAS_flush(RAS_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  // Each predictor write is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (resetn && wr_en) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got pc=%h expected no write", wr_PC);
      end else begin
        ent_t e;
        e = sb.pop_front();
        if ({wr_PC, wr_target, wr_isret, wr_isjump} !== e) begin
          failures++;
          $display("FAIL wr_entry got pc=%h tgt=%h ret=%b jmp=%b expected pc=%h tgt=%h ret=%b jmp=%b",
                   wr_PC, wr_target, wr_isret, wr_isjump, e.pc, e.tgt, e.isret, e.isjump);
        end
      end
    end
  end

  task automatic commit(input logic [1:0] v, br, cl, rt, tk, ptk,
                        input logic [31:0] pc0, pc1, t0, t1, p0, p1);
    int  n;
    logic a0, a1, m0, m1;
    @(negedge clk);
    n = 0;
    while (!cm_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cm_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got cm_ready=%b expected 1", cm_ready);
      return;
    end
    a0 = v[0] & br[0];
    m0 = a0 && ((tk[0] !== ptk[0]) || (tk[0] && (t0 !== p0)));
    a1 = v[1] & br[1] & ~m0;
    m1 = a1 && ((tk[1] !== ptk[1]) || (tk[1] && (t1 !== p1)));
    if (a0) sb.push_back('{pc0, t0, rt[0], tk[0]});
    if (a1) sb.push_back('{pc1, t1, rt[1], tk[1]});
    exp_br  += int'(a0) + int'(a1);
    exp_mis += int'(m0 | m1);
    cm_valid = v; cm_isbranch = br; cm_iscall = cl; cm_isret = rt;
    cm_taken = tk; cm_pred_taken = ptk;
    cm_pc = {pc1, pc0}; cm_target = {t1, t0}; cm_pred_target = {p1, p0};
    @(posedge clk);
    #1;
    cm_valid = '0; cm_isbranch = '0; cm_iscall = '0; cm_isret = '0;
    cm_taken = '0; cm_pred_taken = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic check_redirect(input string name, input logic [31:0] pc,
                                input logic en, input logic fl, input logic [63:0] data);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== pc || RAS_reset_en !== en || RAS_flush !== fl) begin
      failures++;
      $display("FAIL %s got v=%b pc=%h en=%b fl=%b expected v=1 pc=%h en=%b fl=%b",
               name, redirect_valid, redirect_pc, RAS_reset_en, RAS_flush, pc, en, fl);
    end
    if (en) begin
      checks++;
      if (RAS_reset_data !== data) begin
        failures++;
        $display("FAIL %s_data got %h expected %h", name, RAS_reset_data, data);
      end
    end
  endtask

  task automatic test_stats(input string name);
    int eb, em;
`ifdef BCU_STATS_EN
    eb = exp_br; em = exp_mis;
`else
    eb = 0; em = 0;
`endif
    checks++;
    if (stat_branches !== 32'(eb) || stat_mispred !== 32'(em)) begin
      failures++;
      $display("FAIL %s got br=%0d mis=%0d expected br=%0d mis=%0d",
               name, stat_branches, stat_mispred, eb, em);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
    exp_br = 0; exp_mis = 0;
    @(negedge clk);
    checks++;
    if (cm_ready !== 1'b1 || wr_en !== 1'b0 || redirect_valid !== 1'b0 ||
        RAS_reset_en !== 1'b0 || RAS_flush !== 1'b0 || RAS_reset_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b wr=%b rv=%b en=%b fl=%b data=%h expected 1 0 0 0 0 0",
               cm_ready, wr_en, redirect_valid, RAS_reset_en, RAS_flush, RAS_reset_data);
    end
    test_stats("reset_stats");
    resetn = 1'b1;
  endtask

  task automatic test_single_branch();
    commit(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01,
           32'h8000_1000, 32'h0, 32'h8000_1040, 32'h0, 32'h8000_1040, 32'h0);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_PC !== 32'h8000_1000 || wr_isjump !== 1'b1 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_branch got wr=%b pc=%h jmp=%b rv=%b expected 1 80001000 1 0",
               wr_en, wr_PC, wr_isjump, redirect_valid);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++)
      commit(2'b11, 2'b11, 2'b00, 2'b00, 2'(k), 2'(k),
             32'h8001_0000 + 32'(16 * k), 32'h8001_0004 + 32'(16 * k),
             32'h8002_0000 + 32'(k), 32'h8002_0100 + 32'(k),
             32'h8002_0000 + 32'(k), 32'h8002_0100 + 32'(k));
    @(negedge clk);
    checks++;
    if (cm_ready !== 1'b0 || wr_en !== 1'b1) begin
      failures++;
      $display("FAIL queue_full got rdy=%b wr=%b expected rdy=0 wr=1", cm_ready, wr_en);
    end
    commit(2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10,
           32'h8001_0020, 32'h8001_0024, 32'h8002_0002, 32'h8002_0102, 32'h8002_0002, 32'h8002_0102);
    wait_drain();
    test_stats("b2b_stats");
  endtask

  task automatic test_ras_call_ret();
    commit(2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00,
           32'h8000_2000, 32'h0, 32'h8000_9000, 32'h0, 32'h8000_9000, 32'h0);
    @(negedge clk);
    check_redirect("call_push", 32'h8000_9000, 1'b1, 1'b0, 64'h0802);
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b0 || RAS_reset_en !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width got rv=%b en=%b expected 0 0", redirect_valid, RAS_reset_en);
    end
    commit(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01,
           32'h8000_9010, 32'h0, 32'h8000_2008, 32'h0, 32'h8000_3000, 32'h0);
    @(negedge clk);
    check_redirect("ret_mispred", 32'h8000_2008, 1'b1, 1'b0, 64'h0);
    wait_drain();
  endtask

  task automatic test_ras_flush();
    commit(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01,
           32'h8000_4100, 32'h0, 32'h8000_4000, 32'h0, 32'h8000_5000, 32'h0);
    @(negedge clk);
    check_redirect("ret_empty_flush", 32'h8000_4000, 1'b0, 1'b1, 64'h0);
    wait_drain();
  endtask

  task automatic test_slot1_mispredict();
    // Slot1 ret must see the RAS after slot0's call.
    commit(2'b11, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11,
           32'h8000_6000, 32'h8000_6004, 32'h8000_7000, 32'h8000_6008, 32'h8000_7000, 32'h8000_8000);
    @(negedge clk);
    check_redirect("slot1_ret", 32'h8000_6008, 1'b1, 1'b0, 64'h0);
    wait_drain();
    test_stats("slot1_stats");
  endtask

  task automatic test_slot0_drop();
    int eb, em;
    test_reset();
    commit(2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01,
           32'h8000_0100, 32'h8000_0104, 32'h8000_0200, 32'h8000_0300, 32'h8000_0200, 32'h8000_0300);
    @(negedge clk);
    check_redirect("slot0_nt", 32'h8000_0108, 1'b1, 1'b0, 64'h0);
`ifdef BCU_STATS_EN
    eb = 1; em = 1;
`else
    eb = 0; em = 0;
`endif
    checks++;
    if (stat_branches !== 32'(eb) || stat_mispred !== 32'(em)) begin
      failures++;
      $display("FAIL drop_stats got br=%0d mis=%0d expected br=%0d mis=%0d",
               stat_branches, stat_mispred, eb, em);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 2; k++)
      commit(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00,
             32'h8003_0000 + 32'(8 * k), 32'h8003_0004 + 32'(8 * k),
             32'h8004_0000, 32'h8004_0004, 32'h8004_0000, 32'h8004_0004);
    test_reset();
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard got wr=%b expected 0", wr_en);
    end
    commit(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00,
           32'h0, 32'h8005_0000, 32'h0, 32'h8005_0040, 32'h0, 32'h8005_0040);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single_branch();
    test_back_to_back();
    test_ras_call_ret();
    test_ras_flush();
    test_slot1_mispredict();
    test_slot0_drop();
    test_reset_mid_drain();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
